// File: rtl/band_pkg.sv
// rtl/band_pkg.sv - shared types and defaults for the band filter sequencer
package band_pkg;

  localparam int DEFAULT_FREQ_W    = 32;
  localparam int DEFAULT_NUM_BANDS = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BREAK  = 2'd1,
    ST_SETTLE = 2'd2
  } band_state_e;

  // Bounds are stored at the default width; narrower FREQ_W values are zero-extended.
  typedef struct packed {
    logic [DEFAULT_FREQ_W-1:0] lo;
    logic [DEFAULT_FREQ_W-1:0] hi;
    logic                      en;
  } band_entry_t;

endpackage

// File: rtl/band_match.sv
// rtl/band_match.sv - two-stage table compare, hysteresis and priority encode
module band_match
  import band_pkg::*;
#(
  parameter int  FREQ_W    = DEFAULT_FREQ_W,
  parameter int  NUM_BANDS = DEFAULT_NUM_BANDS,
  parameter int  HYST_HZ   = 10000,
  localparam int IDX_W     = $clog2(NUM_BANDS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [FREQ_W-1:0] freq,
  input  band_entry_t       entries [NUM_BANDS],
  input  logic [IDX_W-1:0]  cur_band,
  input  logic              tx,
  output logic [IDX_W-1:0]  cand
);

  localparam logic [FREQ_W:0] HYST_EXT = (FREQ_W+1)'(HYST_HZ);

  logic [NUM_BANDS-1:1] hit_d, hit_q;
  logic                 hyst_d, hyst_q;
  logic [IDX_W-1:0]     cur_s1_d, cur_s1_q;
  logic                 tx_s1_d, tx_s1_q;
  logic [IDX_W-1:0]     cand_d, cand_q;

  band_entry_t          cur_ent;
  logic [FREQ_W-1:0]    cur_lo, cur_hi, win_lo, win_hi;
  logic [FREQ_W:0]      lo_ext, hi_sum;

  always_comb begin
    hit_d = '0;
    for (int k = 1; k < NUM_BANDS; k++) begin
      hit_d[k] = entries[k].en
              && (freq >= FREQ_W'(entries[k].lo))
              && (freq <  FREQ_W'(entries[k].hi));
    end
  end

  // Widened window of the band currently applied, saturating at both ends.
  always_comb begin
    cur_ent  = entries[cur_band];
    cur_lo   = FREQ_W'(cur_ent.lo);
    cur_hi   = FREQ_W'(cur_ent.hi);
    lo_ext   = {1'b0, cur_lo};
    hi_sum   = {1'b0, cur_hi} + HYST_EXT;
    win_lo   = (lo_ext >= HYST_EXT) ? FREQ_W'(lo_ext - HYST_EXT) : '0;
    win_hi   = hi_sum[FREQ_W] ? '1 : hi_sum[FREQ_W-1:0];
    hyst_d   = (cur_band != '0) && cur_ent.en && (freq >= win_lo) && (freq < win_hi);
    cur_s1_d = cur_band;
    tx_s1_d  = tx;
  end

  // Lowest enabled match wins unless the held band or transmit overrides it.
  always_comb begin
    cand_d = '0;
    for (int k = NUM_BANDS - 1; k >= 1; k--) begin
      if (hit_q[k]) cand_d = IDX_W'(k);
    end
    if (hyst_q)  cand_d = cur_s1_q;
    if (tx_s1_q) cand_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hit_q    <= '0;
      hyst_q   <= 1'b0;
      cur_s1_q <= '0;
      tx_s1_q  <= 1'b0;
      cand_q   <= '0;
    end else begin
      hit_q    <= hit_d;
      hyst_q   <= hyst_d;
      cur_s1_q <= cur_s1_d;
      tx_s1_q  <= tx_s1_d;
      cand_q   <= cand_d;
    end
  end

  assign cand = cand_q;

endmodule

// File: rtl/band_filter_sequencer.sv
// rtl/band_filter_sequencer.sv - band table, frequency latch and break/settle relay sequencer
module band_filter_sequencer
  import band_pkg::*;
#(
  parameter int  FREQ_W        = DEFAULT_FREQ_W,
  parameter int  NUM_BANDS     = DEFAULT_NUM_BANDS,
  parameter int  BREAK_CYCLES  = 4,
  parameter int  SETTLE_CYCLES = 8,
  parameter int  HYST_HZ       = 10000,
  localparam int IDX_W         = $clog2(NUM_BANDS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [FREQ_W-1:0]    frequency,
  input  logic                 freq_valid,
  input  logic                 tx,
  input  logic                 tbl_we,
  input  logic [IDX_W-1:0]     tbl_addr,
  input  logic [FREQ_W-1:0]    tbl_lo,
  input  logic [FREQ_W-1:0]    tbl_hi,
  input  logic                 tbl_en,
  output logic [NUM_BANDS-1:0] filt_sel,
  output logic                 mute,
  output logic                 busy
);

  localparam int CNT_MAX = (BREAK_CYCLES > SETTLE_CYCLES) ? BREAK_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] BRK_LAST = CNT_W'(BREAK_CYCLES - 1);
  localparam logic [CNT_W-1:0] STL_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [FREQ_W-1:0]    freq_d, freq_q;
  band_entry_t          table_d [NUM_BANDS];
  band_entry_t          table_q [NUM_BANDS];
  band_state_e          state_d, state_q;
  logic [IDX_W-1:0]     target_d, target_q;
  logic [IDX_W-1:0]     cur_d, cur_q;
  logic [CNT_W-1:0]     cnt_d, cnt_q;
  logic [NUM_BANDS-1:0] filt_sel_d, filt_sel_q;
  logic                 mute_d, mute_q;
  logic [IDX_W-1:0]     cand;

  band_match #(
    .FREQ_W    (FREQ_W),
    .NUM_BANDS (NUM_BANDS),
    .HYST_HZ   (HYST_HZ)
  ) u_match (
    .clock    (clock),
    .reset    (reset),
    .freq     (freq_q),
    .entries  (table_q),
    .cur_band (cur_q),
    .tx       (tx),
    .cand     (cand)
  );

  // Entry 0 is the bypass path and is never writable.
  always_comb begin
    freq_d = freq_valid ? frequency : freq_q;
    for (int k = 0; k < NUM_BANDS; k++) begin
      table_d[k] = table_q[k];
      if (k != 0 && tbl_we && tbl_addr == IDX_W'(k)) begin
        table_d[k].lo = DEFAULT_FREQ_W'(tbl_lo);
        table_d[k].hi = DEFAULT_FREQ_W'(tbl_hi);
        table_d[k].en = tbl_en;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    cur_d      = cur_q;
    cnt_d      = cnt_q;
    filt_sel_d = filt_sel_q;
    mute_d     = mute_q;
    case (state_q)
      ST_IDLE: begin
        if (cand != cur_q) begin
          state_d    = ST_BREAK;
          target_d   = cand;
          cnt_d      = '0;
          filt_sel_d = '0;
          mute_d     = 1'b1;
        end
      end
      ST_BREAK: begin
        // Retargeting keeps the break timer running.
        target_d = cand;
        if (cnt_q == BRK_LAST) begin
          state_d    = ST_SETTLE;
          cur_d      = target_d;
          filt_sel_d = NUM_BANDS'(1) << target_d;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cand != cur_q) begin
          state_d    = ST_BREAK;
          target_d   = cand;
          cnt_d      = '0;
          filt_sel_d = '0;
        end else if (cnt_q == STL_LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          mute_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      freq_q     <= '0;
      state_q    <= ST_IDLE;
      target_q   <= '0;
      cur_q      <= '0;
      cnt_q      <= '0;
      filt_sel_q <= NUM_BANDS'(1);
      mute_q     <= 1'b0;
      for (int k = 0; k < NUM_BANDS; k++) begin
        table_q[k] <= '0;
      end
    end else begin
      freq_q     <= freq_d;
      state_q    <= state_d;
      target_q   <= target_d;
      cur_q      <= cur_d;
      cnt_q      <= cnt_d;
      filt_sel_q <= filt_sel_d;
      mute_q     <= mute_d;
      for (int k = 0; k < NUM_BANDS; k++) begin
        table_q[k] <= table_d[k];
      end
    end
  end

  assign filt_sel = filt_sel_q;
  assign mute     = mute_q;
  assign busy     = (state_q != ST_IDLE);

  a_sel_onehot0: assert property (@(posedge clock) $onehot0(filt_sel_q));

endmodule

// File: tb/tb_band_filter_sequencer.sv
// tb/tb_band_filter_sequencer.sv - randomized and directed checks against a behavioural model
module tb_band_filter_sequencer;

  localparam int    NB   = 8;
  localparam int    BRK  = 4;
  localparam int    STL  = 8;
  localparam int    HYST = 10000;
  localparam longint MAXF = 64'd4294967295;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] frequency;
  logic        freq_valid;
  logic        tx;
  logic        tbl_we;
  logic [2:0]  tbl_addr;
  logic [31:0] tbl_lo;
  logic [31:0] tbl_hi;
  logic        tbl_en;
  logic [7:0]  filt_sel;
  logic        mute;
  logic        busy;

  band_filter_sequencer dut (
    .clock      (clock),
    .reset      (reset),
    .frequency  (frequency),
    .freq_valid (freq_valid),
    .tx         (tx),
    .tbl_we     (tbl_we),
    .tbl_addr   (tbl_addr),
    .tbl_lo     (tbl_lo),
    .tbl_hi     (tbl_hi),
    .tbl_en     (tbl_en),
    .filt_sel   (filt_sel),
    .mute       (mute),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(string nm, longint act, longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: table, latched frequency, two-deep candidate delay, countdown sequencer.
  longint m_lo [NB];
  longint m_hi [NB];
  bit     m_en [NB];
  longint m_f;
  int     m_cur, m_s1, m_cand, m_target, m_brk, m_stl;
  logic [7:0] m_sel;
  bit     m_mute;
  bit     model_ok = 1'b0;
  int     s1_new, cand_new;

  function automatic int decide(longint f, int cur, bit txi);
    longint wl, wh;
    if (txi) return 0;
    if (cur > 0 && m_en[cur]) begin
      wl = m_lo[cur] - HYST;
      if (wl < 0) wl = 0;
      wh = m_hi[cur] + HYST;
      if (wh > MAXF) wh = MAXF;
      if (f >= wl && f < wh) return cur;
    end
    for (int k = 1; k < NB; k++) begin
      if (m_en[k] && f >= m_lo[k] && f < m_hi[k]) return k;
    end
    return 0;
  endfunction

  task automatic model_step();
    if (reset) begin
      for (int k = 0; k < NB; k++) begin
        m_lo[k] = 0; m_hi[k] = 0; m_en[k] = 0;
      end
      m_f = 0; m_cur = 0; m_s1 = 0; m_cand = 0; m_target = 0;
      m_brk = 0; m_stl = 0; m_sel = 8'h01; m_mute = 0;
      model_ok = 1'b1;
    end else begin
      s1_new   = decide(m_f, m_cur, tx);
      cand_new = m_s1;
      if (m_brk > 0) begin
        m_target = m_cand;
        if (m_brk == 1) begin
          m_brk = 0;
          m_cur = m_target;
          m_sel = 8'(1 << m_target);
          m_stl = STL;
        end else begin
          m_brk--;
        end
      end else if (m_stl > 0) begin
        if (m_cand != m_cur) begin
          m_brk = BRK; m_stl = 0; m_target = m_cand; m_sel = 8'h00;
        end else if (m_stl == 1) begin
          m_stl = 0; m_mute = 0;
        end else begin
          m_stl--;
        end
      end else if (m_cand != m_cur) begin
        m_brk = BRK; m_target = m_cand; m_sel = 8'h00; m_mute = 1;
      end
      m_s1   = s1_new;
      m_cand = cand_new;
      if (freq_valid) m_f = frequency;
      if (tbl_we && tbl_addr != 0) begin
        m_lo[tbl_addr] = tbl_lo;
        m_hi[tbl_addr] = tbl_hi;
        m_en[tbl_addr] = tbl_en;
      end
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  initial forever begin
    @(negedge clock);
    if (model_ok) begin
      check("cyc_sel", filt_sel, m_sel);
      check("cyc_mute", mute, m_mute);
      check("cyc_busy", busy, (m_brk > 0 || m_stl > 0));
      check("cyc_onehot0", $onehot0(filt_sel), 1);
    end
  end

  int n_zero, n_busy, n_seen;
  logic [7:0] watch_sel;

  task automatic clr_tally(logic [7:0] w);
    n_zero = 0; n_busy = 0; n_seen = 0; watch_sel = w;
  endtask

  task automatic tick();
    @(negedge clock);
    if (filt_sel == 8'h00) n_zero++;
    if (busy) n_busy++;
    if (filt_sel == watch_sel) n_seen++;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr_entry(int a, longint lo, longint hi, bit en);
    tbl_we = 1'b1; tbl_addr = 3'(a); tbl_lo = 32'(lo); tbl_hi = 32'(hi); tbl_en = en;
    tick();
    tbl_we = 1'b0;
  endtask

  task automatic send_freq(longint f);
    frequency = 32'(f); freq_valid = 1'b1;
    tick();
    freq_valid = 1'b0;
  endtask

  function automatic longint pick_freq();
    int     sel;
    int     k;
    longint f;
    sel = $urandom_range(0, 9);
    k   = $urandom_range(1, NB - 1);
    if (sel < 3) begin
      f = $urandom_range(0, 3000000);
    end else if (sel < 6) begin
      f = m_lo[k] + longint'($urandom_range(0, 4)) * (HYST / 2) - HYST;
    end else if (sel < 9) begin
      f = m_hi[k] + longint'($urandom_range(0, 4)) * (HYST / 2) - HYST - 1 + $urandom_range(0, 2);
    end else begin
      f = MAXF - $urandom_range(0, 2);
    end
    if (f < 0) f = 0;
    if (f > MAXF) f = MAXF;
    return f;
  endfunction

  logic [7:0] exp_sel;
  bit         exp_mute;
  longint     rlo;

  initial begin
    reset = 1'b1; frequency = '0; freq_valid = 1'b0; tx = 1'b0;
    tbl_we = 1'b0; tbl_addr = '0; tbl_lo = '0; tbl_hi = '0; tbl_en = 1'b0;
    clr_tally(8'h00);
    run(2);
    check("rst_sel", filt_sel, 8'h01);
    check("rst_mute", mute, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    run(2);

    // Basic switch into band 1 with literal per-cycle timing.
    wr_entry(1, 1800000, 2000000, 1);
    send_freq(1900000);
    for (int i = 1; i <= 16; i++) begin
      tick();
      exp_sel  = (i < 3) ? 8'h01 : (i < 7) ? 8'h00 : 8'h02;
      exp_mute = (i >= 3 && i <= 14);
      check("seq_sel", filt_sel, exp_sel);
      check("seq_mute", mute, exp_mute);
      check("seq_busy", busy, exp_mute);
    end

    // Hysteresis hold and release.
    clr_tally(8'h00);
    send_freq(2005000);
    run(20);
    check("hyst_hold_sel", filt_sel, 8'h02);
    check("hyst_hold_busy", n_busy, 0);
    clr_tally(8'h00);
    send_freq(2010000);
    run(20);
    check("hyst_exit_sel", filt_sel, 8'h01);
    check("hyst_exit_breaks", n_zero, BRK);

    // Overlapping entries: lowest index wins.
    wr_entry(2, 3500000, 4000000, 1);
    wr_entry(3, 3800000, 4200000, 1);
    send_freq(3900000);
    run(20);
    check("overlap_sel", filt_sel, 8'h04);

    // Retarget during BREAK: a single break of unchanged length.
    clr_tally(8'h02);
    send_freq(1900000);
    run(3);
    check("rt_brk_in_break", filt_sel, 8'h00);
    send_freq(4100000);
    run(25);
    check("rt_brk_sel", filt_sel, 8'h08);
    check("rt_brk_zeros", n_zero, BRK);
    check("rt_brk_no_band1", n_seen, 0);

    // Retarget during SETTLE: a second full break.
    clr_tally(8'h02);
    send_freq(1900000);
    run(8);
    check("rt_stl_in_settle", filt_sel, 8'h02);
    send_freq(4100000);
    run(25);
    check("rt_stl_sel", filt_sel, 8'h08);
    check("rt_stl_zeros", n_zero, 2 * BRK);

    // Transmit forces bypass and releases back to the tuned band.
    wr_entry(5, 7000000, 7300000, 1);
    send_freq(7100000);
    run(20);
    check("tx_pre_sel", filt_sel, 8'h20);
    clr_tally(8'h00);
    tx = 1'b1;
    run(20);
    check("tx_on_sel", filt_sel, 8'h01);
    check("tx_on_zeros", n_zero, BRK);
    tx = 1'b0;
    run(20);
    check("tx_off_sel", filt_sel, 8'h20);

    // Reset in the middle of SETTLE.
    send_freq(1900000);
    run(9);
    check("rst_mid_busy_before", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_sel", filt_sel, 8'h01);
    check("rst_mid_mute", mute, 0);
    check("rst_mid_busy", busy, 0);
    clr_tally(8'h00);
    send_freq(1900000);
    run(20);
    check("rst_tbl_cleared_sel", filt_sel, 8'h01);
    check("rst_tbl_cleared_busy", n_busy, 0);

    // Randomized traffic; the per-cycle compare against the model does the checking.
    wr_entry(4, 5000, 300000, 1);
    wr_entry(6, 32'hFFFF0000, 32'hFFFFFFF0, 1);
    for (int c = 0; c < 4000; c++) begin
      freq_valid = ($urandom_range(0, 99) < 6);
      frequency  = 32'(pick_freq());
      tbl_we     = ($urandom_range(0, 99) < 2);
      tbl_addr   = 3'($urandom_range(0, NB - 1));
      rlo        = ($urandom_range(0, 9) == 0) ? longint'($urandom_range(0, 15000))
                                                : longint'($urandom_range(0, 3000000));
      tbl_lo     = 32'(rlo);
      tbl_hi     = 32'(rlo + $urandom_range(0, 600000));
      tbl_en     = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) < 2) tx = ~tx;
      reset      = ($urandom_range(0, 999) == 0);
      tick();
    end
    reset = 1'b0; tbl_we = 1'b0; freq_valid = 1'b0; tx = 1'b0;
    run(30);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
